uart_tx_fifo: RTL and testbench

Byte buffer placed directly upstream of the UART driver's transmit port. It accepts words from user logic on a valid/ready write interface and stores them in a circular FIFO. It then presents them one at a time to the driver's i_user_tx_data/i_user_tx_valid/o_user_tx_ready handshake. This decouples bursty user writes from the slow serial line and reports level, full, empty and overflow status.

---
 rtl/uart_tx_fifo_if.sv | 65 ++++++
 rtl/uart_tx_fifo.sv | 135 +++++++++++++
 tb/tb_uart_tx_fifo.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_fifo_if.sv
// rtl/uart_tx_fifo_if.sv - write-side, driver-side and status signals of uart_tx_fifo
//
// Purpose: groups every non-clock/reset signal of uart_tx_fifo into one bundle.
//   slave  modport : the FIFO itself (consumes i_*, drives o_*).
//   master modport : the surrounding logic (user writer, UART driver, status reader).
//
// Signals:
//   i_wr_data   [P_UART_DATA_WIDTH-1:0]  word to enqueue
//   i_wr_valid                           user offers i_wr_data
//   o_wr_ready                           FIFO can accept a word this cycle
//   o_tx_data   [P_UART_DATA_WIDTH-1:0]  head word towards the driver
//   o_tx_valid                           head word is valid
//   i_tx_ready                           driver accepts the head word
//   i_flush                              synchronous clear of all contents
//   i_ovf_clr                            clears the sticky overflow flag
//   o_count     [P_ADDR_WIDTH:0]         words held, output stage included
//   o_full / o_empty / o_overflow        status flags

interface uart_tx_fifo_if #(
  parameter int P_UART_DATA_WIDTH = 8,
  parameter int P_ADDR_WIDTH      = 4
);
  logic [P_UART_DATA_WIDTH-1:0] i_wr_data;
  logic                         i_wr_valid;
  logic                         o_wr_ready;
  logic [P_UART_DATA_WIDTH-1:0] o_tx_data;
  logic                         o_tx_valid;
  logic                         i_tx_ready;
  logic                         i_flush;
  logic                         i_ovf_clr;
  logic [P_ADDR_WIDTH:0]        o_count;
  logic                         o_full;
  logic                         o_empty;
  logic                         o_overflow;

  modport slave (
    input  i_wr_data,
    input  i_wr_valid,
    output o_wr_ready,
    output o_tx_data,
    output o_tx_valid,
    input  i_tx_ready,
    input  i_flush,
    input  i_ovf_clr,
    output o_count,
    output o_full,
    output o_empty,
    output o_overflow
  );

  modport master (
    output i_wr_data,
    output i_wr_valid,
    input  o_wr_ready,
    input  o_tx_data,
    input  o_tx_valid,
    output i_tx_ready,
    output i_flush,
    output i_ovf_clr,
    input  o_count,
    input  o_full,
    input  o_empty,
    input  o_overflow
  );
endinterface

// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - circular byte FIFO feeding the UART driver transmit handshake
//
// Purpose: buffers bursty user writes and presents them one at a time to the
//   UART driver through a registered valid/ready output stage.
//
// Ports:
//   clock  : system clock, rising edge
//   reset  : asynchronous, active-low reset
//   bus    : uart_tx_fifo_if.slave (write side, driver side, status)
//
// Structure: words live in a RAM addressed by wr_ptr/rd_ptr. The head word is
//   copied into the tx_data/tx_valid flops. o_count counts both the RAM words
//   and the word held in the output stage.

module uart_tx_fifo #(
  parameter int P_UART_DATA_WIDTH = 8,
  parameter int P_FIFO_DEPTH      = 16,
  parameter int P_ADDR_WIDTH      = 4
) (
  input logic           clock,
  input logic           reset,
  uart_tx_fifo_if.slave bus
);

  localparam logic [P_ADDR_WIDTH:0]   L_FULL_COUNT = (P_ADDR_WIDTH+1)'(P_FIFO_DEPTH);
  localparam logic [P_ADDR_WIDTH:0]   L_CNT_ONE    = (P_ADDR_WIDTH+1)'(1);
  localparam logic [P_ADDR_WIDTH-1:0] L_PTR_ONE    = (P_ADDR_WIDTH)'(1);

  logic [P_UART_DATA_WIDTH-1:0] mem [0:P_FIFO_DEPTH-1];

  logic [P_ADDR_WIDTH-1:0]      wr_ptr;
  logic [P_ADDR_WIDTH-1:0]      rd_ptr;
  logic [P_ADDR_WIDTH:0]        count;
  logic [P_ADDR_WIDTH:0]        mem_count;
  logic [P_UART_DATA_WIDTH-1:0] tx_data;
  logic                         tx_valid;
  logic                         overflow;

  logic full;
  logic wr_en;
  logic rd_en;
  logic load;
  logic mem_nonempty;
  logic bypass;
  logic mem_wr;
  logic mem_rd;

  assign full  = (count == L_FULL_COUNT);
  assign wr_en = bus.i_wr_valid && !full;
  assign rd_en = tx_valid && bus.i_tx_ready;

  // The output stage refills whenever it is empty or its word leaves this edge.
  assign load = !tx_valid || rd_en;

  // Words still in the RAM, i.e. not yet copied into the output stage.
  assign mem_count    = count - {{P_ADDR_WIDTH{1'b0}}, tx_valid};
  assign mem_nonempty = (mem_count != '0);

  // A write landing while the only word leaves goes straight to the output
  // stage, so a steady write+read stream keeps o_tx_valid high at count 1.
  // With the output stage empty the word goes through the RAM instead, which
  // gives the one-cycle fill latency into an empty FIFO.
  assign bypass = rd_en && wr_en && !mem_nonempty;
  assign mem_wr = wr_en && !bypass && !bus.i_flush;
  assign mem_rd = load && mem_nonempty;

  // Storage has no reset; stale contents are never presented.
  always_ff @(posedge clock) begin
    if (mem_wr) begin
      mem[wr_ptr] <= bus.i_wr_data;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      tx_data  <= '0;
      tx_valid <= 1'b0;
    end else if (bus.i_flush) begin
      // Flush beats any write or read in the same cycle; tx_data is left as is
      // because it is meaningless while tx_valid is low.
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      tx_valid <= 1'b0;
    end else begin
      if (mem_wr) begin
        wr_ptr <= wr_ptr + L_PTR_ONE;
      end
      if (mem_rd) begin
        rd_ptr <= rd_ptr + L_PTR_ONE;
      end

      case ({wr_en, rd_en})
        2'b10:   count <= count + L_CNT_ONE;
        2'b01:   count <= count - L_CNT_ONE;
        default: count <= count;
      endcase

      if (load) begin
        if (mem_nonempty) begin
          tx_data  <= mem[rd_ptr];
          tx_valid <= 1'b1;
        end else if (bypass) begin
          tx_data  <= bus.i_wr_data;
          tx_valid <= 1'b1;
        end else begin
          tx_valid <= 1'b0;
        end
      end
    end
  end

  // Sticky overflow: a set in the same cycle as a clear wins. Flush leaves it.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      overflow <= 1'b0;
    end else if (bus.i_wr_valid && full) begin
      overflow <= 1'b1;
    end else if (bus.i_ovf_clr) begin
      overflow <= 1'b0;
    end
  end

  assign bus.o_wr_ready = !full;
  assign bus.o_tx_data  = tx_data;
  assign bus.o_tx_valid = tx_valid;
  assign bus.o_count    = count;
  assign bus.o_full     = full;
  assign bus.o_empty    = (count == '0);
  assign bus.o_overflow = overflow;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb/tb_uart_tx_fifo.sv - directed self-checking bench for uart_tx_fifo

module tb_uart_tx_fifo;

  logic clock;
  logic reset;
  int   n_assert;
  int   n_fail;

  uart_tx_fifo_if #(.P_UART_DATA_WIDTH(8), .P_ADDR_WIDTH(4)) bus ();

  uart_tx_fifo #(
    .P_UART_DATA_WIDTH(8),
    .P_FIFO_DEPTH(16),
    .P_ADDR_WIDTH(4)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus(bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_count"},    32'(bus.o_count), 32'd0);
    chk({tag, "_tx_valid"}, 32'(bus.o_tx_valid), 32'd0);
    chk({tag, "_tx_data"},  32'(bus.o_tx_data), 32'h00);
    chk({tag, "_empty"},    32'(bus.o_empty), 32'd1);
    chk({tag, "_full"},     32'(bus.o_full), 32'd0);
    chk({tag, "_overflow"}, 32'(bus.o_overflow), 32'd0);
    chk({tag, "_wr_ready"}, 32'(bus.o_wr_ready), 32'd1);
  endtask

  initial begin
    n_assert = 0;
    n_fail   = 0;
    reset    = 1'b0;
    bus.i_wr_data  = '0;
    bus.i_wr_valid = 1'b0;
    bus.i_tx_ready = 1'b0;
    bus.i_flush    = 1'b0;
    bus.i_ovf_clr  = 1'b0;

    // Reset state
    #2;
    chk_reset_state("rst");
    tick();
    tick();
    reset = 1'b1;
    tick();
    chk_reset_state("rst_rel");

    // Single word, stalled driver
    bus.i_wr_data  = 8'hA5;
    bus.i_wr_valid = 1'b1;
    tick();
    bus.i_wr_valid = 1'b0;
    chk("a5_count_n",   32'(bus.o_count), 32'd1);
    chk("a5_valid_n",   32'(bus.o_tx_valid), 32'd0);
    tick();
    chk("a5_valid_n1",  32'(bus.o_tx_valid), 32'd1);
    chk("a5_data_n1",   32'(bus.o_tx_data), 32'hA5);
    chk("a5_count_n1",  32'(bus.o_count), 32'd1);
    chk("a5_empty_n1",  32'(bus.o_empty), 32'd0);
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("a5_stall_data",  32'(bus.o_tx_data), 32'hA5);
      chk("a5_stall_valid", 32'(bus.o_tx_valid), 32'd1);
    end
    bus.i_tx_ready = 1'b1;
    tick();
    bus.i_tx_ready = 1'b0;
    chk("a5_drain_valid", 32'(bus.o_tx_valid), 32'd0);
    chk("a5_drain_empty", 32'(bus.o_empty), 32'd1);

    // Fill to full (pointers start at 1, so the write pointer wraps)
    for (int i = 0; i < 16; i++) begin
      bus.i_wr_data  = 8'(i);
      bus.i_wr_valid = 1'b1;
      tick();
    end
    chk("fill_count",    32'(bus.o_count), 32'd16);
    chk("fill_full",     32'(bus.o_full), 32'd1);
    chk("fill_wr_ready", 32'(bus.o_wr_ready), 32'd0);
    chk("fill_ovf_pre",  32'(bus.o_overflow), 32'd0);
    bus.i_wr_data = 8'h10;
    tick();
    chk("ovf_set",       32'(bus.o_overflow), 32'd1);
    chk("ovf_count",     32'(bus.o_count), 32'd16);
    bus.i_wr_data = 8'h11;
    bus.i_ovf_clr = 1'b1;
    tick();
    bus.i_ovf_clr  = 1'b0;
    bus.i_wr_valid = 1'b0;
    chk("ovf_set_wins",  32'(bus.o_overflow), 32'd1);
    chk("ovf_count2",    32'(bus.o_count), 32'd16);
    bus.i_tx_ready = 1'b1;
    for (int k = 0; k < 16; k++) begin
      chk("drain_valid", 32'(bus.o_tx_valid), 32'd1);
      chk("drain_data",  32'(bus.o_tx_data), 32'(k));
      tick();
      chk("drain_count", 32'(bus.o_count), 32'(15 - k));
    end
    chk("drain_empty",   32'(bus.o_empty), 32'd1);
    chk("drain_valid_end", 32'(bus.o_tx_valid), 32'd0);
    bus.i_tx_ready = 1'b0;

    // Streaming write+read at count 1
    bus.i_wr_data  = 8'h40;
    bus.i_wr_valid = 1'b1;
    tick();
    bus.i_wr_valid = 1'b0;
    tick();
    chk("stream_first", 32'(bus.o_tx_data), 32'h40);
    chk("stream_count0", 32'(bus.o_count), 32'd1);
    bus.i_tx_ready = 1'b1;
    for (int i = 1; i < 40; i++) begin
      bus.i_wr_data  = 8'(8'h40 + i);
      bus.i_wr_valid = 1'b1;
      chk("stream_valid", 32'(bus.o_tx_valid), 32'd1);
      chk("stream_data",  32'(bus.o_tx_data), 32'(8'h40 + i - 1));
      tick();
      chk("stream_count", 32'(bus.o_count), 32'd1);
    end
    bus.i_wr_valid = 1'b0;
    chk("stream_last", 32'(bus.o_tx_data), 32'h67);
    tick();
    bus.i_tx_ready = 1'b0;
    chk("stream_empty", 32'(bus.o_empty), 32'd1);

    // Slow driver: one accept every 10 cycles after a burst of 8
    for (int i = 0; i < 8; i++) begin
      bus.i_wr_data  = 8'(8'h31 + i);
      bus.i_wr_valid = 1'b1;
      tick();
    end
    bus.i_wr_valid = 1'b0;
    chk("slow_peak", 32'(bus.o_count), 32'd8);
    for (int k = 0; k < 8; k++) begin
      for (int j = 0; j < 9; j++) tick();
      chk("slow_hold", 32'(bus.o_count), 32'(8 - k));
      chk("slow_data", 32'(bus.o_tx_data), 32'(8'h31 + k));
      bus.i_tx_ready = 1'b1;
      tick();
      bus.i_tx_ready = 1'b0;
      chk("slow_count", 32'(bus.o_count), 32'(7 - k));
    end
    for (int j = 0; j < 10; j++) tick();
    chk("slow_done_valid", 32'(bus.o_tx_valid), 32'd0);
    chk("slow_done_empty", 32'(bus.o_empty), 32'd1);

    // Flush beats a simultaneous write and read; overflow untouched
    for (int i = 0; i < 5; i++) begin
      bus.i_wr_data  = 8'(8'h50 + i);
      bus.i_wr_valid = 1'b1;
      tick();
    end
    bus.i_wr_valid = 1'b0;
    tick();
    chk("flush_pre_count", 32'(bus.o_count), 32'd5);
    chk("flush_pre_data",  32'(bus.o_tx_data), 32'h50);
    bus.i_flush    = 1'b1;
    bus.i_wr_data  = 8'hFF;
    bus.i_wr_valid = 1'b1;
    bus.i_tx_ready = 1'b1;
    tick();
    bus.i_flush    = 1'b0;
    bus.i_wr_valid = 1'b0;
    bus.i_tx_ready = 1'b0;
    chk("flush_count", 32'(bus.o_count), 32'd0);
    chk("flush_valid", 32'(bus.o_tx_valid), 32'd0);
    chk("flush_ovf",   32'(bus.o_overflow), 32'd1);
    tick();
    tick();
    chk("flush_ff_dropped", 32'(bus.o_tx_valid), 32'd0);
    chk("flush_count2",     32'(bus.o_count), 32'd0);
    bus.i_ovf_clr = 1'b1;
    tick();
    bus.i_ovf_clr = 1'b0;
    chk("ovf_clear", 32'(bus.o_overflow), 32'd0);

    // Flush leaves pointers coherent: new word appears normally
    bus.i_wr_data  = 8'h77;
    bus.i_wr_valid = 1'b1;
    tick();
    bus.i_wr_valid = 1'b0;
    tick();
    chk("post_flush_data", 32'(bus.o_tx_data), 32'h77);
    bus.i_tx_ready = 1'b1;
    tick();
    bus.i_tx_ready = 1'b0;

    // Asynchronous reset mid-cycle while holding 10 words
    for (int i = 0; i < 10; i++) begin
      bus.i_wr_data  = 8'(8'h80 + i);
      bus.i_wr_valid = 1'b1;
      tick();
    end
    bus.i_wr_valid = 1'b0;
    tick();
    chk("pre_areset_count", 32'(bus.o_count), 32'd10);
    chk("pre_areset_data",  32'(bus.o_tx_data), 32'h80);
    #2;
    reset = 1'b0;
    #1;
    chk_reset_state("areset");
    #2;
    reset = 1'b1;
    tick();
    chk_reset_state("areset_rel");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
